fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Instruction-fetch stage directly downstream of the PC block. Takes the current PC, issues reads to a synchronous instruction memory (1-cycle read latency), and queues the returned {pc, instruction} pairs in a small FIFO.
- Hands queued pairs to decode over a valid/ready handshake.
- Back-pressures the PC block with pc_stall and discards all queued and in-flight work on flush (taken branch / trigger).

Parameters:
- ADDRESS_WIDTH, 8, width of PC and instruction-memory address.
- DATA_WIDTH, 32, instruction width.
- DEPTH, 2, FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pc_in  input  ADDRESS_WIDTH  current PC from the PC block.
- flush  input  1  discard queue and in-flight fetch; PC block redirects in the same cycle.
- imem_req  output  1  read request to instruction memory this cycle.
- imem_addr  output  ADDRESS_WIDTH  read address; equals pc_in.
- imem_rdata  input  DATA_WIDTH  read data, valid in the cycle after imem_req.
- pc_stall  output  1  PC block must hold its value this cycle.
- instr_valid  output  1  head entry valid toward decode.
- instr_ready  input  1  decode accepts head entry.
- instr_out  output  DATA_WIDTH  head instruction.
- instr_pc_out  output  ADDRESS_WIDTH  PC of head instruction.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, FIFO pointers=0, inflight=0, kill=0.
  - instr_valid=0; instr_out and instr_pc_out=0.
  - imem_req forced 0, so pc_stall=1.
  - Release is synchronous to clk; the first request may issue in the first cycle after release.
- pop = instr_valid & instr_ready.
- Issue rule (combinational):
  - imem_req = rst & ~flush & (count + inflight - pop < DEPTH).
  - The pop credit lets a full-throughput stream sustain 1 instruction per cycle.
- pc_stall = ~imem_req. imem_addr = pc_in at all times.
- In-flight tracking:
  - On an issuing edge: inflight<=1 and inflight_pc<=pc_in. Otherwise inflight<=0.
  - On a flush edge: kill<=inflight_next. The response of a request issued before flush is never issued, because a request is blocked during flush.
  - Additionally, any response arriving in a flush cycle is dropped.
- Response (cycle where inflight=1, kill=0, flush=0): push {inflight_pc, imem_rdata} at the write pointer.
  - Guaranteed not to overflow by the issue rule; an assertion checks this.
- Pop: on pop the read pointer advances.
  - The next entry appears on instr_out / instr_pc_out in the cycle after the edge.
  - Outputs are driven from registered FIFO storage; there is no fall-through, so push-to-valid latency is 1 cycle.
- Simultaneous push and pop: count unchanged, both pointers advance. Pop when count=0 is impossible (instr_valid=0).
- Flush (synchronous, highest priority):
  - count<=0, pointers<=0, pending response dropped, no request in the flush cycle.
  - instr_valid=0 from the next cycle.
  - Flush with an empty queue is harmless.
- Pointers wrap modulo DEPTH.
- instr_valid = (count != 0). instr_out and instr_pc_out hold stable while instr_valid=1 and instr_ready=0.
- Total latency, pc_in to instr_valid: 2 cycles (request cycle, response/push cycle, then valid).

Decomposition:
- Shared package (cpu_pkg): ADDRESS_WIDTH and DATA_WIDTH defaults, plus packed struct fetch_entry_t {pc, instr}.
- One sub-module: fetch_fifo (parameterised DEPTH). It has push/pop, registered storage, count and a synchronous clear.
- fetch_buffer keeps only the issue, in-flight and kill logic.

Test Plan:
- Reset: hold rst=0 for 3 cycles with pc_in=8'h10.
  - -> imem_req=0, pc_stall=1, instr_valid=0, count=0.
  - Release -> imem_req=1 on the next cycle.
- Streaming: imem returns 32'hA000_0000+addr; instr_ready=1; PC increments by 4 from 0.
  - -> after 2-cycle latency, instr_valid is held 1.
  - -> instr_pc_out = 0,4,8,... with matching instr_out; one instruction per cycle; count ≤ 1.
- Back-pressure: instr_ready=0 from cycle 5.
  - -> count reaches 2 and pc_stall=1.
  - -> head holds pc 8'h08 stable.
  - Release ready -> entries drain in order with no loss or duplicate.
- Flush with full queue and an in-flight request: flush=1 for one cycle, pc_in=8'h40.
  - -> next cycle count=0, instr_valid=0, pending response dropped.
  - -> first delivered instruction has pc 8'h40.
- Back-to-back flushes on 2 consecutive cycles.
  - -> no push occurs, imem_req=0 in both cycles.
  - -> resumes cleanly afterwards.
- Async reset asserted mid-stream between clock edges.
  - -> outputs clear immediately (instr_valid=0, imem_req=0).
  - -> the stale in-flight response is never pushed after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-path types: default bus widths and the {pc, instr} entry queued toward decode.
package cpu_pkg;

    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_DATA_WIDTH    = 32;

    typedef struct packed {
        logic [DEF_ADDRESS_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0]    instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO of fetch entries; the head is read straight from storage (no fall-through).
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_pop;

    assign do_pop = pop & (count_q != '0);

    // Pointers are exactly PW bits wide, so the +1 wraps modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !do_pop && !clear && count_q == (PW+1)'(DEPTH)));

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: issues instruction-memory reads from pc_in, tracks the one in-flight response,
// and queues {pc, instr} pairs for decode; flush discards everything queued or in flight.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int DEPTH         = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDRESS_WIDTH-1:0]   pc_in,
    input  logic                       flush,
    output logic                       imem_req,
    output logic [ADDRESS_WIDTH-1:0]   imem_addr,
    input  logic [DATA_WIDTH-1:0]      imem_rdata,
    output logic                       pc_stall,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [DATA_WIDTH-1:0]      instr_out,
    output logic [ADDRESS_WIDTH-1:0]   instr_pc_out,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                     inflight_q;
    logic                     kill_q;
    logic [ADDRESS_WIDTH-1:0] inflight_pc_q;
    logic                     pop;
    logic                     push;
    logic [CW:0]              occupancy;
    fetch_entry_t             push_entry;
    fetch_entry_t             head;

    assign pop = instr_valid & instr_ready;

    // Counting the pop as a free slot is what lets a steady stream issue every cycle.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign imem_req  = rst & ~flush & (occupancy < (CW+1)'(DEPTH));
    assign pc_stall  = ~imem_req;
    assign imem_addr = pc_in;

    assign push             = inflight_q & ~kill_q & ~flush;
    assign push_entry.pc    = inflight_pc_q;
    assign push_entry.instr = imem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                inflight_pc_q <= pc_in;
            end
            // Requests are blocked during flush, so this stays 0; kept as a guard on the push path.
            kill_q <= flush ? imem_req : 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .valid      (instr_valid),
        .count      (count)
    );

    assign instr_out    = head.instr;
    assign instr_pc_out = head.pc;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: transaction-level reference queue plus negedge scoreboard monitor.
module tb_fetch_buffer;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] pc_in = 8'h10;
    logic          flush = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata = '0;
    logic          pc_stall;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] instr_pc_out;
    logic [1:0]    count;

    fetch_buffer #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .flush        (flush),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .pc_stall     (pc_stall),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_out    (instr_out),
        .instr_pc_out (instr_pc_out),
        .count        (count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] imem_fn(input logic [AW-1:0] a);
        return 32'hA000_0000 + {24'h0, a};
    endfunction

    // Synchronous instruction memory: data for a request appears in the next cycle, garbage otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? imem_fn(imem_addr) : $urandom();
    end

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
    } exp_t;

    exp_t          exp_q[$];
    bit            m_inflight;
    logic [AW-1:0] m_inflight_pc;
    bit            issued_q;
    int            n_checks = 0;
    int            n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Scoreboard monitor: compares DUT outputs against the reference queue, then advances the model.
    int sz;
    bit m_pop;
    bit m_req;
    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_req", 64'(imem_req), 64'd0);
            chk("reset_stall", 64'(pc_stall), 64'd1);
            chk("reset_valid", 64'(instr_valid), 64'd0);
            chk("reset_count", 64'(count), 64'd0);
            exp_q.delete();
            m_inflight = 1'b0;
            issued_q   = 1'b0;
        end else begin
            sz = exp_q.size();
            chk("count", 64'(count), 64'(sz));
            chk("valid", 64'(instr_valid), 64'(sz != 0));
            if (sz != 0) begin
                chk("head_pc", 64'(instr_pc_out), 64'(exp_q[0].pc));
                chk("head_instr", 64'(instr_out), 64'(exp_q[0].instr));
            end
            m_pop = (sz != 0) && instr_ready;
            m_req = !flush && ((sz + int'(m_inflight) - int'(m_pop)) < DEPTH);
            chk("imem_req", 64'(imem_req), 64'(m_req));
            chk("pc_stall", 64'(pc_stall), 64'(!m_req));
            chk("imem_addr", 64'(imem_addr), 64'(pc_in));
            if (m_pop) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (m_inflight) exp_q.push_back(exp_t'{pc: m_inflight_pc, instr: imem_fn(m_inflight_pc)});
            m_inflight = m_req;
            if (m_req) m_inflight_pc = pc_in;
            issued_q = imem_req;
        end
    end

    // PC block model: advance by 4 after an issued request, redirect on flush.
    task automatic cyc(input bit fl, input logic [AW-1:0] tgt, input bit rdy);
        @(posedge clk);
        #1;
        if (issued_q) pc_in = pc_in + 8'd4;
        flush = fl;
        if (fl) pc_in = tgt;
        instr_ready = rdy;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        n_err++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        bit fl;
        rst = 1'b0;
        pc_in = 8'h10;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        pc_in = 8'h00;
        instr_ready = 1'b1;

        repeat (12) cyc(1'b0, 8'h00, 1'b1);

        repeat (5) cyc(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        chk("bp_count_full", 64'(count), 64'd2);
        chk("bp_stall", 64'(pc_stall), 64'd1);
        repeat (6) cyc(1'b0, 8'h00, 1'b1);

        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h40, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        #1;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(instr_valid), 64'd0);
        repeat (6) cyc(1'b0, 8'h00, 1'b1);

        cyc(1'b1, 8'h60, 1'b1);
        cyc(1'b1, 8'h70, 1'b1);
        repeat (6) cyc(1'b0, 8'h00, 1'b1);

        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_valid", 64'(instr_valid), 64'd0);
        chk("async_req", 64'(imem_req), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        flush = 1'b0;
        pc_in = 8'h80;
        instr_ready = 1'b1;
        repeat (8) cyc(1'b0, 8'h00, 1'b1);

        repeat (400) begin
            fl = ($urandom_range(0, 19) == 0);
            cyc(fl, 8'($urandom()), $urandom_range(0, 9) < 7);
        end
        repeat (5) cyc(1'b0, 8'h00, 1'b1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
